// File: rtl/ctrl_barrido_codigos_pkg.sv
// Shared definitions for the day-label scan sequencer: FSM state encodings,
// day code constants produced by the encoder, and the miss counter limit.
package ctrl_barrido_codigos_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_SEND   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Day codes returned by the encoder; CODE_NONE marks an unmapped tile.
  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_L    = 3'd1;
  localparam logic [2:0] CODE_N    = 3'd2;
  localparam logic [2:0] CODE_C    = 3'd3;
  localparam logic [2:0] CODE_D    = 3'd4;
  localparam logic [2:0] CODE_S    = 3'd5;
  localparam logic [2:0] CODE_V    = 3'd6;

  localparam logic [3:0] MISS_MAX = 4'd15;

  // Increment that sticks at MISS_MAX instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == MISS_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/ctrl_barrido_codigos.sv
// Scan sequencer for the day-label encoder. Walks an N_ROWS x N_COLS grid of
// tile addresses row-major, drives MSB/LSB to the encoder, samples its code
// after one settle cycle and streams {index, code} over valid/ready.
module ctrl_barrido_codigos
  import ctrl_barrido_codigos_pkg::*;
#(
  parameter logic [4:0] MSB_BASE = 5'b01110,
  parameter logic [4:0] MSB_STEP = 5'd2,
  parameter logic [6:0] LSB_BASE = 7'b0100110,
  parameter logic [6:0] LSB_STEP = 7'd2,
  parameter int         N_ROWS   = 2,
  parameter int         N_COLS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] MSB,
  output logic [6:0] LSB,
  input  logic [2:0] ASCII,
  output logic [2:0] code_out,
  output logic [3:0] code_idx,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] miss_cnt
);

  localparam logic [1:0] ROW_LAST = 2'(N_ROWS - 1);
  localparam logic [1:0] COL_LAST = 2'(N_COLS - 1);
  localparam logic [3:0] N_COLS_W = 4'(N_COLS);

  state_t     state_q;
  logic [1:0] row_q;
  logic [1:0] col_q;
  logic [4:0] msb_q;
  logic [6:0] lsb_q;
  logic [2:0] code_q;
  logic [3:0] idx_q;
  logic       valid_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] miss_q;

  logic [3:0] cur_idx;
  logic       last_tile;

  // Linear tile index and end-of-grid detection from the row/col counters.
  assign cur_idx   = 4'(row_q) * N_COLS_W + 4'(col_q);
  assign last_tile = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Sequencer FSM with all outputs registered; addresses advance incrementally
  // so MSB/LSB wrap modulo their widths without multipliers.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // reset is synchronous, so it only takes effect on a clock edge.
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      msb_q   <= MSB_BASE;
      lsb_q   <= LSB_BASE;
      code_q  <= 3'd0;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      miss_q  <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            msb_q   <= MSB_BASE;
            lsb_q   <= LSB_BASE;
            miss_q  <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          code_q  <= ASCII;
          idx_q   <= cur_idx;
          valid_q <= 1'b1;
          if (ASCII == CODE_NONE) miss_q <= sat_inc(miss_q);
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (code_ready) begin
            valid_q <= 1'b0;
            if (last_tile) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              if (col_q == COL_LAST) begin
                col_q <= 2'd0;
                row_q <= row_q + 2'd1;
                lsb_q <= LSB_BASE;
                msb_q <= msb_q + MSB_STEP;
              end else begin
                col_q <= col_q + 2'd1;
                lsb_q <= lsb_q + LSB_STEP;
              end
              state_q <= ST_ADDR;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign MSB        = msb_q;
  assign LSB        = lsb_q;
  assign code_out   = code_q;
  assign code_idx   = idx_q;
  assign code_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign miss_cnt   = miss_q;

endmodule
